stream_mux_rr: RTL and testbench

- Parametrised N-channel, WIDTH-bit streaming multiplexer; successor to the combinational 4:1 mux with enable.
- Each input channel has a valid/ready handshake. The output is a single registered stage with valid/ready.
- Two selection modes: fixed (external select `se`) and round-robin arbitration among valid channels.
- Sits between multiple producers and one shared consumer.

---
 rtl/stream_mux_rr.sv | 66 ++++++
 tb/tb_stream_mux_rr.sv | 118 +++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with fixed or round-robin select and one registered output slot.
module stream_mux_rr #(
  parameter int WIDTH = 3,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      se,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d, last_ch_q, last_ch_d, gnt;
  logic             out_valid_q, out_valid_d, gnt_v, slot_free, load;
  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    if (!mode) begin
      for (int i = 0; i < N_CH; i++)
        if (se == SEL_W'(i) && in_valid[i]) begin
          gnt_v = 1'b1;
          gnt   = SEL_W'(i);
        end
    end else begin
      // walk the scan order backwards so the earliest valid channel after last_ch wins
      for (int k = N_CH; k >= 1; k--)
        if (in_valid[(int'(last_ch_q) + k) % N_CH]) begin
          gnt_v = 1'b1;
          gnt   = SEL_W'((int'(last_ch_q) + k) % N_CH);
        end
    end
  end
  assign slot_free = !out_valid_q || out_ready;
  assign load      = en && slot_free && gnt_v;
  assign in_ready  = (rst_n && load) ? (N_CH'(1) << gnt) : '0;
  always_comb begin
    out_valid_d = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d  = load ? in_data[int'(gnt)*WIDTH +: WIDTH] : out_data_q;
    out_ch_d    = load ? gnt : out_ch_q;
    last_ch_d   = (load && mode) ? gnt : last_ch_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_ch_q   <= SEL_W'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_ch_q   <= last_ch_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed vector table plus an async-reset sequence for stream_mux_rr.
module tb_stream_mux_rr;
  logic        clk = 1'b0;
  logic        rst_n, en, mode, out_ready, out_valid;
  logic [1:0]  se, out_ch;
  logic [11:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [2:0]  out_data;
  int          total = 0, bad = 0;

  typedef struct {
    logic       en, mode;
    logic [1:0] se;
    logic [3:0] v;
    logic       ordy;
    logic [3:0] ir;
    logic       ov;
    logic [2:0] od;
    logic [1:0] oc;
  } vec_t;
  vec_t vq[$];

  stream_mux_rr #(.WIDTH(3), .N_CH(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .se(se),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic void add(logic e, logic m, logic [1:0] s, logic [3:0] v, logic r,
                              logic [3:0] ir, logic ov, logic [2:0] od, logic [1:0] oc);
    vq.push_back('{e, m, s, v, r, ir, ov, od, oc});
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // expected out_* are the registered values before the edge that applies the vector
    for (int i = 0; i < 5; i++) add(0, 0, 0, 4'hf, 1, 4'b0000, 0, 0, 0);
    add(1, 0, 0, 4'hf, 1, 4'b0001, 0, 0, 0);
    add(1, 0, 1, 4'hf, 1, 4'b0010, 1, 0, 0);
    add(1, 0, 2, 4'hf, 1, 4'b0100, 1, 1, 1);
    add(1, 0, 3, 4'hf, 1, 4'b1000, 1, 2, 2);
    add(1, 1, 0, 4'hf, 1, 4'b0001, 1, 3, 3);
    add(1, 1, 0, 4'hf, 1, 4'b0010, 1, 0, 0);
    add(1, 1, 0, 4'hf, 1, 4'b0100, 1, 1, 1);
    add(1, 1, 0, 4'hf, 1, 4'b1000, 1, 2, 2);
    add(1, 1, 0, 4'hf, 1, 4'b0001, 1, 3, 3);
    add(1, 1, 0, 4'hf, 1, 4'b0010, 1, 0, 0);
    add(1, 1, 0, 4'hf, 1, 4'b0100, 1, 1, 1);
    add(1, 1, 0, 4'hf, 1, 4'b1000, 1, 2, 2);
    add(1, 1, 0, 4'ha, 1, 4'b0010, 1, 3, 3);
    add(1, 1, 0, 4'ha, 1, 4'b1000, 1, 1, 1);
    add(1, 1, 0, 4'ha, 1, 4'b0010, 1, 3, 3);
    add(1, 1, 0, 4'ha, 1, 4'b1000, 1, 1, 1);
    add(1, 1, 0, 4'ha, 1, 4'b0010, 1, 3, 3);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 4'ha, 0, 4'b0000, 1, 1, 1);
    add(1, 1, 0, 4'ha, 1, 4'b1000, 1, 1, 1);
    add(1, 1, 0, 4'h0, 1, 4'b0000, 1, 3, 3);
    add(1, 1, 0, 4'h0, 1, 4'b0000, 0, 3, 3);
    add(1, 0, 1, 4'hd, 1, 4'b0000, 0, 3, 3);
    add(1, 0, 2, 4'h4, 1, 4'b0100, 0, 3, 3);
    add(0, 0, 2, 4'hf, 1, 4'b0000, 1, 2, 2);
    add(0, 0, 2, 4'hf, 1, 4'b0000, 0, 2, 2);
    add(0, 1, 0, 4'hf, 1, 4'b0000, 0, 2, 2);

    in_data = {3'd3, 3'd2, 3'd1, 3'd0};
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; se = '0; in_valid = 4'hf; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      en = vq[i].en; mode = vq[i].mode; se = vq[i].se; in_valid = vq[i].v; out_ready = vq[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vq[i].ir));
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vq[i].ov));
      if (vq[i].ov) begin
        check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vq[i].od));
        check($sformatf("v%0d_out_ch", i), 32'(out_ch), 32'(vq[i].oc));
      end
    end

    // load ch0 then ch1 in round-robin, then reset between edges
    @(negedge clk);
    en = 1'b1; mode = 1'b1; in_valid = 4'hf; out_ready = 1'b1;
    #1 check("rst_seq_gnt0", 32'(in_ready), 32'b0001);
    @(negedge clk);
    #1 check("rst_seq_gnt1", 32'(in_ready), 32'b0010);
    check("rst_seq_data0", 32'(out_data), 32'd0);
    @(posedge clk);
    #1 check("rst_seq_pre_data", 32'(out_data), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_data", 32'(out_data), 32'd0);
    check("rst_async_ch", 32'(out_ch), 32'd0);
    check("rst_async_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_gnt", 32'(in_ready), 32'b0001);
    @(negedge clk);
    #1;
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_ch", 32'(out_ch), 32'd0);
    check("post_rst_data", 32'(out_data), 32'd0);
    check("post_rst_next_gnt", 32'(in_ready), 32'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
